// File: rtl/calc_pkg.sv
// Shared calculator number format and seven-segment encodings.
// Segment vectors are {a,b,c,d,e,f,g} in bits {6..0}, active high.
package calc_pkg;

    localparam int NumDigits = 8;
    localparam int ExpW      = $clog2(NumDigits);

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // exponent = position of the digit carrying the decimal point (0 = none)
    typedef struct packed {
        logic                  error;
        logic                  sign;
        logic [ExpW-1:0]       exponent;
        bcd_t [NumDigits-1:0]  significand;
    } num_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_MINUS = 7'b0000001;

    function automatic seg_t bcd2segments(input bcd_t bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/calc_display_digit.sv
// Combinational decode of one digit position into segments and decimal point.
// An error value shows 'E' on the rightmost digit and blanks everything else.
module calc_display_digit
    import calc_pkg::*;
(
    input  bcd_t bcd,
    input  logic blank,
    input  logic dp_en,
    input  logic error,
    input  logic first,
    output seg_t seg,
    output logic dp
);

    always_comb begin
        seg = SEG_BLANK;
        dp  = 1'b0;
        if (error) begin
            if (first) begin
                seg = SEG_E;
            end
        end else begin
            if (!blank) begin
                seg = bcd2segments(bcd);
            end
            dp = dp_en;
        end
    end

endmodule

// File: rtl/calc_display_scan.sv
// Multiplexed seven-segment scanner: one digit selected per ScanDiv cycles.
// New values are double-buffered and only swapped in at a frame boundary.
module calc_display_scan #(
    parameter int NumDigits         = calc_pkg::NumDigits,
    parameter int ScanDiv           = 1000,
    parameter int BlankLeadingZeros = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 valid_i,
    input  calc_pkg::num_t       num_i,
    output logic [NumDigits-1:0] digit_sel_o,
    output calc_pkg::seg_t       seg_o,
    output logic                 dp_o,
    output logic                 sign_o
);

    import calc_pkg::*;

    localparam int CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int IdxW = $clog2(NumDigits);
    localparam logic [CntW-1:0] CntLast = CntW'(ScanDiv - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumDigits - 1);

    logic [CntW-1:0] cnt;
    logic [IdxW-1:0] idx;
    logic            tick;
    logic            frame_end;

    num_t            pending_q;
    num_t            active_q;
    logic            pending_vld;

    bcd_t            sel_bcd;
    logic            upper_zero;
    logic            nonzero;
    logic            blank;
    logic            dp_en;
    logic            first;
    seg_t            seg_d;
    logic            dp_d;

    assign tick      = enable_i && (cnt == CntLast);
    assign frame_end = tick && (idx == IdxLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable_i) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IdxLast) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // While blanked nothing is on screen, so updates bypass the frame buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            pending_vld <= 1'b0;
            active_q    <= '0;
        end else if (!enable_i) begin
            pending_vld <= 1'b0;
            if (valid_i) begin
                active_q <= num_i;
            end
        end else if (frame_end) begin
            pending_vld <= 1'b0;
            if (valid_i) begin
                active_q <= num_i;
            end else if (pending_vld) begin
                active_q <= pending_q;
            end
        end else if (valid_i) begin
            pending_q   <= num_i;
            pending_vld <= 1'b1;
        end
    end

    always_comb begin
        sel_bcd    = '0;
        upper_zero = 1'b1;
        nonzero    = 1'b0;
        for (int i = 0; i < NumDigits; i++) begin
            if (IdxW'(i) == idx) begin
                sel_bcd = active_q.significand[i];
            end
            if (active_q.significand[i] != '0) begin
                nonzero = 1'b1;
                if (i >= int'(idx)) begin
                    upper_zero = 1'b0;
                end
            end
        end
    end

    // A digit left of the point is blank only if it and everything above it is zero.
    assign blank = (BlankLeadingZeros != 0)
                && (int'(idx) > int'(active_q.exponent))
                && upper_zero;
    assign dp_en = (int'(idx) == int'(active_q.exponent)) && (active_q.exponent != '0);
    assign first = (idx == '0);

    calc_display_digit u_digit (
        .bcd   (sel_bcd),
        .blank (blank),
        .dp_en (dp_en),
        .error (active_q.error),
        .first (first),
        .seg   (seg_d),
        .dp    (dp_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_sel_o <= '0;
            seg_o       <= SEG_BLANK;
            dp_o        <= 1'b0;
            sign_o      <= 1'b0;
        end else if (!enable_i) begin
            digit_sel_o <= '0;
            seg_o       <= SEG_BLANK;
            dp_o        <= 1'b0;
            sign_o      <= 1'b0;
        end else begin
            digit_sel_o <= {{(NumDigits-1){1'b0}}, 1'b1} << idx;
            seg_o       <= seg_d;
            dp_o        <= dp_d;
            sign_o      <= active_q.sign && !active_q.error && nonzero;
        end
    end

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench: expected digit outputs are queued per frame and popped as the scan runs.
module tb_calc_display_scan;
    import calc_pkg::*;

    localparam int ND = 8;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          vld;
    num_t          num;
    logic [ND-1:0] sel;
    seg_t          seg;
    logic          dp;
    logic          sgn;

    int vectors     = 0;
    int miscompares = 0;
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    calc_display_scan #(
        .NumDigits         (ND),
        .ScanDiv           (SD),
        .BlankLeadingZeros (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (en),
        .valid_i     (vld),
        .num_i       (num),
        .digit_sel_o (sel),
        .seg_o       (seg),
        .dp_o        (dp),
        .sign_o      (sgn)
    );

    function automatic seg_t tb_seg(input logic [3:0] b);
        case (b)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // {digit_sel, seg, dp, sign} for digit d of value v
    function automatic logic [16:0] exp_out(input num_t v, input int d);
        int           msd = -1;
        int           e;
        logic [7:0]   s;
        seg_t         sg;
        logic         p;
        logic         m;
        e = int'(v.exponent);
        for (int k = 0; k < ND; k++) begin
            if (v.significand[k] != 4'h0) msd = k;
        end
        s = 8'(1 << d);
        if (v.error) begin
            sg = (d == 0) ? 7'b1001111 : 7'b0000000;
            p  = 1'b0;
            m  = 1'b0;
        end else begin
            sg = ((d > e) && (d > msd)) ? 7'b0000000 : tb_seg(v.significand[d]);
            p  = (d == e) && (e != 0);
            m  = v.sign && (msd >= 0);
        end
        return {s, sg, p, m};
    endfunction

    function automatic num_t mk(input bit err, input bit s, input int e, input logic [31:0] sig);
        num_t n;
        n.error       = err;
        n.sign        = s;
        n.exponent    = 3'(e);
        n.significand = sig;
        return n;
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input num_t v);
        for (int d = 0; d < ND; d++) sb_q.push_back(exp_out(v, d));
    endtask

    // Starts at the first cycle of a frame; ends at the first cycle of the next.
    task automatic check_frame(input string tag, input int sa_cyc, input num_t sa,
                               input int sb_cyc, input num_t sb);
        logic [16:0] e;
        e = '0;
        for (int c = 0; c < 2 * ND; c++) begin
            if (c % 2 == 0) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, {sel, seg, dp, sgn});
                end else begin
                    e = sb_q.pop_front();
                end
            end
            check($sformatf("%s d%0d c%0d", tag, c / 2, c % 2), {sel, seg, dp, sgn}, e);
            if (c == sa_cyc) begin
                vld = 1'b1; num = sa;
            end else if (c == sb_cyc) begin
                vld = 1'b1; num = sb;
            end else begin
                vld = 1'b0;
            end
            @(negedge clk);
        end
        vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        num_t z, a, b, c, d, er, nz, hx, g, h, p;
        z  = mk(0, 0, 0, 32'h0000_0000);
        a  = mk(0, 1, 2, 32'h0000_1234);
        b  = mk(0, 0, 0, 32'h8765_4321);
        c  = mk(0, 0, 5, 32'h0000_0090);
        d  = mk(0, 1, 1, 32'h0000_0007);
        er = mk(1, 1, 3, 32'h1234_5678);
        nz = mk(0, 1, 3, 32'h0000_0000);
        hx = mk(0, 0, 0, 32'h0000_5A3F);
        g  = mk(0, 1, 0, 32'h0000_0666);
        h  = mk(0, 0, 4, 32'h0003_0001);
        p  = mk(0, 1, 0, 32'h9999_9999);

        rst_n = 1'b0; en = 1'b1; vld = 1'b0; num = z;
        @(negedge clk);
        check("reset0", {sel, seg, dp, sgn}, 17'h0);
        @(negedge clk);
        check("reset1", {sel, seg, dp, sgn}, 17'h0);
        rst_n = 1'b1;
        @(negedge clk);

        push_frame(z); check_frame("idle", -1, z, -1, z);
        push_frame(z); check_frame("midstrobe", 6, a, -1, z);
        push_frame(a); check_frame("valA", 4, b, 10, c);
        push_frame(c); check_frame("lastwins", 14, d, -1, z);
        push_frame(d); check_frame("boundary", 14, er, -1, z);
        push_frame(er); check_frame("error", 14, nz, -1, z);
        push_frame(nz); check_frame("negzero", 14, hx, -1, z);
        push_frame(hx); check_frame("bcdgt9", -1, z, -1, z);

        // pending value then display off: pending must be dropped
        vld = 1'b1; num = g;
        @(negedge clk);
        vld = 1'b0; en = 1'b0;
        @(negedge clk);
        check("off0", {sel, seg, dp, sgn}, 17'h0);
        vld = 1'b1; num = h;
        @(negedge clk);
        vld = 1'b0;
        check("off1", {sel, seg, dp, sgn}, 17'h0);
        @(negedge clk);
        check("off2", {sel, seg, dp, sgn}, 17'h0);
        en = 1'b1;
        @(negedge clk);
        push_frame(h); check_frame("reen0", -1, z, -1, z);
        push_frame(h); check_frame("reen1", -1, z, -1, z);

        // reset mid-frame with a pending value
        vld = 1'b1; num = p;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async", {sel, seg, dp, sgn}, 17'h0);
        @(negedge clk);
        check("rst_hold", {sel, seg, dp, sgn}, 17'h0);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(z); check_frame("postrst0", -1, z, -1, z);
        push_frame(z); check_frame("postrst1", -1, z, -1, z);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
